// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanned mux status-capture path.
package mux_scan_pkg;

    // Default channel count and matching select width.
    localparam int NUM_CH_DEF = 16;
    localparam int SEL_W_DEF  = 4;

    // Settle counter width; holds SETTLE-1 for SETTLE up to 15.
    localparam int CNT_W = 4;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational search for the next enabled channel above an index.
// With first_i high the index is ignored (treated as -1), which yields
// the lowest set bit of the mask.
module mux_scan_next_ch
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  idx_i,
    input  logic              first_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              found_o
);

    // Scan downward so the last qualifying hit is the lowest index above idx_i.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(idx_i)))) begin
                next_o  = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a NUM_CH:1 bit mux: steps the select lines through the
// enabled channels, samples each one after it settles, and hands the
// assembled snapshot downstream over valid/ready.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              continuous,
    output logic [SEL_W-1:0]  sel_out,
    input  logic              mux_in,
    output logic [NUM_CH-1:0] snap_data,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic              busy,
    output logic              overrun
);

    // Reload value for the settle counter: SETTLE cycles in ST_SETTLE.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] shadow_d;
    logic [NUM_CH-1:0] snap_q;
    logic              vld_q;
    logic              busy_q;
    logic              ovr_q;

    logic [SEL_W-1:0]  first_idx;
    logic              first_found;
    logic [SEL_W-1:0]  next_idx;
    logic              next_found;

    // Lowest enabled channel of the live mask, used whenever a scan (re)starts.
    mux_scan_next_ch #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_first_ch (
        .mask_i  (ch_mask),
        .idx_i   ('0),
        .first_i (1'b1),
        .next_o  (first_idx),
        .found_o (first_found)
    );

    // Next enabled channel above the current one within the latched mask.
    mux_scan_next_ch #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next_ch (
        .mask_i  (mask_q),
        .idx_i   (sel_q),
        .first_i (1'b0),
        .next_o  (next_idx),
        .found_o (next_found)
    );

    // Shadow word including the bit being sampled this cycle, so the final
    // channel lands in the snapshot on the same edge it is captured.
    always_comb begin
        shadow_d = shadow_q;
        if (state_q == ST_SAMPLE) begin
            shadow_d[sel_q] = mux_in;
        end
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            snap_q   <= '0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            // A start request that arrives outside IDLE is flagged but ignored.
            ovr_q <= start && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (start && first_found) begin
                        mask_q   <= ch_mask;
                        shadow_q <= '0;
                        sel_q    <= first_idx;
                        cnt_q    <= CNT_LOAD;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    shadow_q <= shadow_d;
                    if (next_found) begin
                        sel_q   <= next_idx;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_SETTLE;
                    end else begin
                        snap_q  <= shadow_d;
                        vld_q   <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (vld_q && snap_ready) begin
                        vld_q <= 1'b0;
                        if (continuous && first_found) begin
                            mask_q   <= ch_mask;
                            shadow_q <= '0;
                            sel_q    <= first_idx;
                            cnt_q    <= CNT_LOAD;
                            state_q  <= ST_SETTLE;
                        end else begin
                            sel_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel_out    = sel_q;
    assign snap_data  = snap_q;
    assign snap_valid = vld_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 16:1 mux model.
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ch_mask;
    logic        continuous;
    logic [3:0]  sel_out;
    logic        mux_in;
    logic [15:0] snap_data;
    logic        snap_valid;
    logic        snap_ready;
    logic        busy;
    logic        overrun;

    logic [15:0] mux_vec;
    logic [3:0]  sp_sel [6] = '{4'd0, 4'd0, 4'd8, 4'd8, 4'd15, 4'd15};

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    // Mux model: output follows the selected input immediately.
    assign mux_in = mux_vec[sel_out];

    mux_scan_sequencer #(
        .NUM_CH (16),
        .SEL_W  (4),
        .SETTLE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ch_mask    (ch_mask),
        .continuous (continuous),
        .sel_out    (sel_out),
        .mux_in     (mux_in),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        snap_ready = 1'b1;
        ch_mask    = 16'h0000;
        mux_vec    = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctl", {busy, snap_valid, overrun, sel_out}, 32'h0);
        chk("reset_data", snap_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_release", {busy, snap_valid, overrun, sel_out}, 32'h0);

        // Full scan: 16 channels, 2 cycles each, valid 32 cycles after accept
        mux_vec = 16'hA5C3;
        ch_mask = 16'hFFFF;
        start   = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("full_c%0d", j), {busy, snap_valid, sel_out}, {26'd0, 1'b1, 1'b0, 4'((j - 1) / 2)});
        end
        @(negedge clk);
        chk("full_valid", snap_valid, 32'h1);
        chk("full_data", snap_data, 32'h0000A5C3);
        @(negedge clk);
        chk("full_idle", {busy, snap_valid, sel_out}, 32'h0);

        // Sparse mask: only channels 0, 8, 15 visited
        mux_vec = 16'hFFFF;
        ch_mask = 16'h8101;
        start   = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("sparse_c%0d", j), {busy, snap_valid, sel_out}, {26'd0, 1'b1, 1'b0, sp_sel[j - 1]});
        end
        @(negedge clk);
        chk("sparse_valid", snap_valid, 32'h1);
        chk("sparse_data", snap_data, 32'h00008101);
        @(negedge clk);
        chk("sparse_idle", {busy, snap_valid, sel_out}, 32'h0);

        // Backpressure: snapshot held while snap_ready is low
        snap_ready = 1'b0;
        mux_vec    = 16'h0010;
        ch_mask    = 16'h0011;
        start      = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("bp_scan%0d", j), snap_valid, 32'h0);
        end
        for (int j = 5; j <= 14; j++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", j), {busy, snap_valid}, 32'h3);
            chk($sformatf("bp_data%0d", j), snap_data, 32'h00000010);
            if (j == 9) mux_vec = 16'hFFFF;
        end
        snap_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {busy, snap_valid}, 32'h0);

        // Continuous: back-to-back scans with no idle cycle in between
        continuous = 1'b1;
        snap_ready = 1'b0;
        mux_vec    = 16'h0003;
        ch_mask    = 16'h000F;
        start      = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        chk("cont_valid1", snap_valid, 32'h1);
        chk("cont_data1", snap_data, 32'h00000003);
        mux_vec    = 16'h000C;
        snap_ready = 1'b1;
        for (int j = 10; j <= 17; j++) begin
            @(negedge clk);
            continuous = 1'b0;
            chk($sformatf("cont_rescan%0d", j), {busy, snap_valid, sel_out}, {26'd0, 1'b1, 1'b0, 4'((j - 10) / 2)});
        end
        @(negedge clk);
        chk("cont_valid2", snap_valid, 32'h1);
        chk("cont_data2", snap_data, 32'h0000000C);
        @(negedge clk);
        chk("cont_idle", {busy, snap_valid, sel_out}, 32'h0);

        // Overrun: start while busy pulses overrun once, scan unaffected
        mux_vec = 16'h0002;
        ch_mask = 16'h0003;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovr_accept", {busy, overrun}, 32'h2);
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        ch_mask = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        chk("ovr_pulse", overrun, 32'h1);
        @(negedge clk);
        chk("ovr_clear", overrun, 32'h0);
        chk("ovr_valid", snap_valid, 32'h1);
        chk("ovr_data", snap_data, 32'h00000002);
        @(negedge clk);
        chk("ovr_idle", {busy, snap_valid, overrun, sel_out}, 32'h0);

        // Zero mask in IDLE: ignored, no overrun
        ch_mask = 16'h0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_mask1", {busy, snap_valid, overrun, sel_out}, 32'h0);
        @(negedge clk);
        chk("zero_mask2", {busy, snap_valid, overrun, sel_out}, 32'h0);

        // Reset mid-scan during channel 5, then a clean scan
        mux_vec = 16'hA5C3;
        ch_mask = 16'hFFFF;
        start   = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid_sel5", {busy, sel_out}, 32'h15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {busy, snap_valid, overrun, sel_out}, 32'h0);
        chk("mid_rst_data", snap_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        mux_vec = 16'h1234;
        start   = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 1 || j == 32)
                chk($sformatf("clean_c%0d", j), {busy, snap_valid, sel_out}, {26'd0, 1'b1, 1'b0, 4'((j - 1) / 2)});
        end
        @(negedge clk);
        chk("clean_valid", snap_valid, 32'h1);
        chk("clean_data", snap_data, 32'h00001234);
        @(negedge clk);
        chk("clean_idle", {busy, snap_valid, sel_out}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
